// File: rtl/se_bus_pkg.sv
// Shared definitions for the secure-element bus sequencer: opcodes, core
// addresses, FSM state encoding and the layout of the 64-bit control word.
package se_bus_pkg;

    // Host command opcodes
    localparam logic [1:0] OP_WRITE    = 2'b00;
    localparam logic [1:0] OP_READ     = 2'b01;
    localparam logic [1:0] OP_EXEC     = 2'b10;
    localparam logic [1:0] OP_DESELECT = 2'b11;

    // Core (module) addresses carried in the upper half of the control word
    localparam logic [31:0] MOD_NONE   = 32'h0000_0000;
    localparam logic [31:0] MOD_SHA2   = 32'h0000_0020;
    localparam logic [31:0] MOD_SHA3   = 32'h0000_0030;
    localparam logic [31:0] MOD_EDDSA  = 32'h0000_0040;
    localparam logic [31:0] MOD_X25519 = 32'h0000_0050;
    localparam logic [31:0] MOD_TRNG   = 32'h0000_0060;
    localparam logic [31:0] MOD_AES    = 32'h0000_0070;

    // Control word field positions
    localparam int CTRL_LSB = 0;
    localparam int CTRL_MSB = 31;
    localparam int MOD_LSB  = 32;
    localparam int MOD_MSB  = 63;

    // Leading EXEC_WAIT cycles in which end_op may still be the previous op's flag
    localparam int STALE_CYC = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_READ_WAIT,
        ST_EXEC_WAIT,
        ST_RESP
    } state_t;

    // Build the 64-bit control word from a core address and its control bits
    function automatic logic [63:0] pack_control(input logic [31:0] module_addr,
                                                 input logic [31:0] ctrl);
        return {module_addr, ctrl};
    endfunction

endpackage

// File: rtl/se_op_timer.sv
// Loadable up-counter used to time the DRIVE, READ_WAIT and EXEC_WAIT phases.
// Clear has priority over load, load over count; the count saturates at all-ones.
module se_op_timer #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         enable,
    input  logic [W-1:0] tc_value,
    output logic [W-1:0] count,
    output logic         at_tc,
    output logic         saturated
);

    logic [W-1:0] count_reg;

    // Counter register with clear/load/saturating increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (enable && !saturated) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count     = count_reg;
    assign at_tc     = (count_reg == tc_value);
    assign saturated = &count_reg;

endmodule

// File: rtl/se_bus_master.sv
// Command sequencer driving the secure-element data/address/control bus.
// Accepts one host command at a time, holds it on the bus, optionally waits
// for read data or the core's end-of-operation flag, then returns a response.
module se_bus_master #(
    parameter int DRIVE_CYC = 2,
    parameter int READ_LAT  = 2,
    parameter int TIMEOUT_W = 24
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [1:0]  i_cmd_op,
    input  logic [31:0] i_cmd_module,
    input  logic [31:0] i_cmd_ctrl,
    input  logic [63:0] i_cmd_add,
    input  logic [63:0] i_cmd_data,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [63:0] o_rsp_data,
    output logic        o_rsp_timeout,
    output logic [63:0] o_se_data_in,
    output logic [63:0] o_se_add,
    output logic [63:0] o_se_control,
    input  logic [63:0] i_se_data_out,
    input  logic        i_se_end_op
);
    import se_bus_pkg::*;

    // The shared timer is TIMEOUT_W wide; DRIVE_CYC and READ_LAT must fit in it
    localparam logic [TIMEOUT_W-1:0] DRIVE_TC  = TIMEOUT_W'(DRIVE_CYC - 1);
    localparam logic [TIMEOUT_W-1:0] READ_TC   = TIMEOUT_W'(READ_LAT - 1);
    localparam logic [TIMEOUT_W-1:0] EXEC_LOAD = TIMEOUT_W'(1);
    localparam logic [TIMEOUT_W-1:0] STALE_TC  = TIMEOUT_W'(STALE_CYC);

    state_t      state_reg, state_next;
    logic [1:0]  op_reg, op_next;
    logic        cmd_ready_reg, cmd_ready_next;
    logic        rsp_valid_reg, rsp_valid_next;
    logic [63:0] rsp_data_reg, rsp_data_next;
    logic        rsp_timeout_reg, rsp_timeout_next;
    logic [63:0] se_data_reg, se_data_next;
    logic [63:0] se_add_reg, se_add_next;
    logic [63:0] se_control_reg, se_control_next;

    logic                 timer_clear, timer_load, timer_en;
    logic [TIMEOUT_W-1:0] timer_tc, timer_count;
    logic                 timer_at_tc, timer_saturated;

    // Counts cycles spent in DRIVE and READ_WAIT, and wait cycles (1-based) in EXEC_WAIT
    se_op_timer #(
        .W(TIMEOUT_W)
    ) u_timer (
        .clk        (i_clk),
        .rst        (i_rst),
        .clear      (timer_clear),
        .load       (timer_load),
        .load_value (EXEC_LOAD),
        .enable     (timer_en),
        .tc_value   (timer_tc),
        .count      (timer_count),
        .at_tc      (timer_at_tc),
        .saturated  (timer_saturated)
    );

    // State and registered-output update
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg       <= ST_IDLE;
            op_reg          <= OP_WRITE;
            cmd_ready_reg   <= 1'b1;
            rsp_valid_reg   <= 1'b0;
            rsp_data_reg    <= '0;
            rsp_timeout_reg <= 1'b0;
            se_data_reg     <= '0;
            se_add_reg      <= '0;
            se_control_reg  <= '0;
        end else begin
            state_reg       <= state_next;
            op_reg          <= op_next;
            cmd_ready_reg   <= cmd_ready_next;
            rsp_valid_reg   <= rsp_valid_next;
            rsp_data_reg    <= rsp_data_next;
            rsp_timeout_reg <= rsp_timeout_next;
            se_data_reg     <= se_data_next;
            se_add_reg      <= se_add_next;
            se_control_reg  <= se_control_next;
        end
    end

    // Next-state and next-output logic; everything holds unless a transition changes it
    always_comb begin
        state_next       = state_reg;
        op_next          = op_reg;
        cmd_ready_next   = cmd_ready_reg;
        rsp_valid_next   = rsp_valid_reg;
        rsp_data_next    = rsp_data_reg;
        rsp_timeout_next = rsp_timeout_reg;
        se_data_next     = se_data_reg;
        se_add_next      = se_add_reg;
        se_control_next  = se_control_reg;
        timer_clear      = 1'b0;
        timer_load       = 1'b0;
        timer_en         = 1'b0;
        timer_tc         = (state_reg == ST_READ_WAIT) ? READ_TC : DRIVE_TC;

        case (state_reg)
            ST_IDLE: begin
                if (i_cmd_valid) begin
                    op_next        = i_cmd_op;
                    cmd_ready_next = 1'b0;
                    se_add_next    = i_cmd_add;
                    se_data_next   = i_cmd_data;
                    // DESELECT is the only way the module select goes back to 0
                    se_control_next = (i_cmd_op == OP_DESELECT) ?
                                      pack_control(MOD_NONE, 32'h0) :
                                      pack_control(i_cmd_module, i_cmd_ctrl);
                    timer_clear    = 1'b1;
                    state_next     = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                timer_en = 1'b1;
                if (timer_at_tc) begin
                    case (op_reg)
                        OP_READ: begin
                            timer_clear = 1'b1;
                            state_next  = ST_READ_WAIT;
                        end
                        OP_EXEC: begin
                            se_control_next[CTRL_MSB:CTRL_LSB] = '0;
                            timer_load = 1'b1;
                            state_next = ST_EXEC_WAIT;
                        end
                        default: begin
                            se_add_next      = '0;
                            se_data_next     = '0;
                            se_control_next[CTRL_MSB:CTRL_LSB] = '0;
                            rsp_valid_next   = 1'b1;
                            rsp_data_next    = '0;
                            rsp_timeout_next = 1'b0;
                            state_next       = ST_RESP;
                        end
                    endcase
                end
            end
            ST_READ_WAIT: begin
                timer_en = 1'b1;
                if (timer_at_tc) begin
                    se_add_next      = '0;
                    se_data_next     = '0;
                    se_control_next[CTRL_MSB:CTRL_LSB] = '0;
                    rsp_valid_next   = 1'b1;
                    rsp_data_next    = i_se_data_out;
                    rsp_timeout_next = 1'b0;
                    state_next       = ST_RESP;
                end
            end
            ST_EXEC_WAIT: begin
                timer_en = 1'b1;
                // end_op wins over a simultaneous timeout
                if ((i_se_end_op && (timer_count > STALE_TC)) || timer_saturated) begin
                    se_add_next      = '0;
                    se_data_next     = '0;
                    rsp_valid_next   = 1'b1;
                    rsp_data_next    = 64'(timer_count);
                    rsp_timeout_next = !(i_se_end_op && (timer_count > STALE_TC));
                    state_next       = ST_RESP;
                end
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    rsp_valid_next   = 1'b0;
                    rsp_data_next    = '0;
                    rsp_timeout_next = 1'b0;
                    cmd_ready_next   = 1'b1;
                    state_next       = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign o_cmd_ready   = cmd_ready_reg;
    assign o_rsp_valid   = rsp_valid_reg;
    assign o_rsp_data    = rsp_data_reg;
    assign o_rsp_timeout = rsp_timeout_reg;
    assign o_se_data_in  = se_data_reg;
    assign o_se_add      = se_add_reg;
    assign o_se_control  = se_control_reg;

endmodule

// File: tb/tb_se_bus_master.sv
// Directed testbench for se_bus_master (DRIVE_CYC=2, READ_LAT=2, TIMEOUT_W=4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_se_bus_master;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic [1:0]  i_cmd_op;
    logic [31:0] i_cmd_module;
    logic [31:0] i_cmd_ctrl;
    logic [63:0] i_cmd_add;
    logic [63:0] i_cmd_data;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [63:0] o_rsp_data;
    logic        o_rsp_timeout;
    logic [63:0] o_se_data_in;
    logic [63:0] o_se_add;
    logic [63:0] o_se_control;
    logic [63:0] i_se_data_out;
    logic        i_se_end_op;

    int total = 0;
    int bad   = 0;

    se_bus_master #(
        .DRIVE_CYC (2),
        .READ_LAT  (2),
        .TIMEOUT_W (4)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_cmd_valid   (i_cmd_valid),
        .o_cmd_ready   (o_cmd_ready),
        .i_cmd_op      (i_cmd_op),
        .i_cmd_module  (i_cmd_module),
        .i_cmd_ctrl    (i_cmd_ctrl),
        .i_cmd_add     (i_cmd_add),
        .i_cmd_data    (i_cmd_data),
        .o_rsp_valid   (o_rsp_valid),
        .i_rsp_ready   (i_rsp_ready),
        .o_rsp_data    (o_rsp_data),
        .o_rsp_timeout (o_rsp_timeout),
        .o_se_data_in  (o_se_data_in),
        .o_se_add      (o_se_add),
        .o_se_control  (o_se_control),
        .i_se_data_out (i_se_data_out),
        .i_se_end_op   (i_se_end_op)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(negedge i_clk);
    endtask

    // Present a command at a falling edge; it is accepted on the next rising
    // edge. Returns in the first bus cycle with valid dropped.
    task automatic issue(input logic [1:0] op, input logic [31:0] mod_addr,
                         input logic [31:0] ctrl, input logic [63:0] add,
                         input logic [63:0] data);
        $display("cmd op=%0d module=%h ctrl=%h add=%h data=%h", op, mod_addr, ctrl, add, data);
        i_cmd_op     = op;
        i_cmd_module = mod_addr;
        i_cmd_ctrl   = ctrl;
        i_cmd_add    = add;
        i_cmd_data   = data;
        i_cmd_valid  = 1'b1;
        tick();
        i_cmd_valid  = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (2) tick();
        total++;
        if ({o_rsp_valid, o_rsp_timeout, o_rsp_data, o_se_data_in, o_se_add, o_se_control} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got rsp_valid=%b data=%h ctl=%h add=%h want all 0",
                     o_rsp_valid, o_rsp_data, o_se_control, o_se_add);
        end
        total++;
        if (o_cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: got %b want 1", o_cmd_ready);
        end
        i_rst = 1'b0;
        tick();
        total++;
        if ({o_cmd_ready, o_rsp_valid} !== 2'b10) begin
            bad++;
            $display("FAIL post_reset_idle: got ready/valid=%b want 10", {o_cmd_ready, o_rsp_valid});
        end
        $display("txn reset done");
    endtask

    task automatic test_write();
        i_rsp_ready = 1'b1;
        issue(2'b00, 32'h50, 32'h1, 64'h3, 64'hDEAD_BEEF);
        for (int k = 1; k <= 2; k++) begin
            total++;
            if ({o_se_control, o_se_add, o_se_data_in, o_rsp_valid} !==
                {64'h0000_0050_0000_0001, 64'h3, 64'hDEAD_BEEF, 1'b0}) begin
                bad++;
                $display("FAIL write_bus_c%0d: got ctl=%h add=%h data=%h valid=%b want 0000005000000001/3/deadbeef/0",
                         k, o_se_control, o_se_add, o_se_data_in, o_rsp_valid);
            end
            tick();
        end
        total++;
        if ({o_se_control, o_se_add, o_se_data_in} !== {64'h0000_0050_0000_0000, 64'h0, 64'h0}) begin
            bad++;
            $display("FAIL write_bus_after: got ctl=%h add=%h data=%h want 0000005000000000/0/0",
                     o_se_control, o_se_add, o_se_data_in);
        end
        total++;
        if ({o_rsp_valid, o_rsp_timeout, o_rsp_data, o_cmd_ready} !== {1'b1, 1'b0, 64'h0, 1'b0}) begin
            bad++;
            $display("FAIL write_rsp: got valid=%b to=%b data=%h ready=%b want 1/0/0/0",
                     o_rsp_valid, o_rsp_timeout, o_rsp_data, o_cmd_ready);
        end
        tick();
        total++;
        if ({o_rsp_valid, o_cmd_ready} !== 2'b01) begin
            bad++;
            $display("FAIL write_one_cycle_rsp: got valid/ready=%b want 01", {o_rsp_valid, o_cmd_ready});
        end
        i_rsp_ready = 1'b0;
        $display("txn write done");
    endtask

    task automatic test_read();
        i_rsp_ready   = 1'b0;
        i_se_data_out = 64'hFFFF_0000_FFFF_0000;
        issue(2'b01, 32'h20, 32'h5, 64'h8, 64'h0);
        for (int k = 1; k <= 4; k++) begin
            total++;
            if ({o_se_control, o_se_add, o_rsp_valid} !== {64'h0000_0020_0000_0005, 64'h8, 1'b0}) begin
                bad++;
                $display("FAIL read_hold_c%0d: got ctl=%h add=%h valid=%b want 0000002000000005/8/0",
                         k, o_se_control, o_se_add, o_rsp_valid);
            end
            if (k == 4) i_se_data_out = 64'h0123_4567_89AB_CDEF;
            tick();
        end
        i_se_data_out = 64'hFFFF_0000_FFFF_0000;
        total++;
        if ({o_rsp_valid, o_rsp_data, o_rsp_timeout} !== {1'b1, 64'h0123_4567_89AB_CDEF, 1'b0}) begin
            bad++;
            $display("FAIL read_rsp: got valid=%b data=%h to=%b want 1/0123456789abcdef/0",
                     o_rsp_valid, o_rsp_data, o_rsp_timeout);
        end
        total++;
        if ({o_se_control, o_se_add} !== {64'h0000_0020_0000_0000, 64'h0}) begin
            bad++;
            $display("FAIL read_bus_after: got ctl=%h add=%h want 0000002000000000/0", o_se_control, o_se_add);
        end
        tick();
        total++;
        if ({o_rsp_valid, o_rsp_data} !== {1'b1, 64'h0123_4567_89AB_CDEF}) begin
            bad++;
            $display("FAIL read_rsp_hold: got valid=%b data=%h want 1/0123456789abcdef", o_rsp_valid, o_rsp_data);
        end
        i_rsp_ready = 1'b1;
        tick();
        i_rsp_ready = 1'b0;
        total++;
        if ({o_rsp_valid, o_cmd_ready} !== 2'b01) begin
            bad++;
            $display("FAIL read_handshake: got valid/ready=%b want 01", {o_rsp_valid, o_cmd_ready});
        end
        $display("txn read done");
    endtask

    task automatic test_exec();
        i_rsp_ready = 1'b0;
        i_se_end_op = 1'b1;
        issue(2'b10, 32'h40, 32'h9, 64'h11, 64'h22);
        total++;
        if (o_se_control !== 64'h0000_0040_0000_0009) begin
            bad++;
            $display("FAIL exec_drive_ctl: got %h want 0000004000000009", o_se_control);
        end
        tick();
        tick();
        total++;
        if (o_se_control !== 64'h0000_0040_0000_0000) begin
            bad++;
            $display("FAIL exec_wait_ctl: got %h want 0000004000000000", o_se_control);
        end
        i_se_end_op = 1'b0;
        for (int k = 3; k <= 12; k++) begin
            total++;
            if (o_rsp_valid !== 1'b0) begin
                bad++;
                $display("FAIL exec_early_rsp_n%0d: got valid=%b data=%h want valid 0", k, o_rsp_valid, o_rsp_data);
            end
            if (k == 12) i_se_end_op = 1'b1;
            tick();
        end
        i_se_end_op = 1'b0;
        total++;
        if ({o_rsp_valid, o_rsp_timeout, o_rsp_data} !== {1'b1, 1'b0, 64'd10}) begin
            bad++;
            $display("FAIL exec_rsp: got valid=%b to=%b data=%0d want 1/0/10", o_rsp_valid, o_rsp_timeout, o_rsp_data);
        end
        i_rsp_ready = 1'b1;
        tick();
        i_rsp_ready = 1'b0;
        total++;
        if ({o_cmd_ready, o_se_control} !== {1'b1, 64'h0000_0040_0000_0000}) begin
            bad++;
            $display("FAIL exec_after: got ready=%b ctl=%h want 1/0000004000000000", o_cmd_ready, o_se_control);
        end
        $display("txn exec done");
    endtask

    task automatic test_timeout();
        i_rsp_ready = 1'b0;
        i_se_end_op = 1'b0;
        issue(2'b10, 32'h60, 32'h2, 64'h0, 64'h0);
        for (int k = 1; k <= 17; k++) begin
            total++;
            if (o_rsp_valid !== 1'b0) begin
                bad++;
                $display("FAIL timeout_early_n%0d: got valid=%b want 0", k, o_rsp_valid);
            end
            tick();
        end
        total++;
        if ({o_rsp_valid, o_rsp_timeout, o_rsp_data} !== {1'b1, 1'b1, 64'd15}) begin
            bad++;
            $display("FAIL timeout_rsp: got valid=%b to=%b data=%0d want 1/1/15", o_rsp_valid, o_rsp_timeout, o_rsp_data);
        end
        i_rsp_ready = 1'b1;
        tick();
        i_rsp_ready = 1'b0;
        total++;
        if ({o_cmd_ready, o_rsp_valid} !== 2'b10) begin
            bad++;
            $display("FAIL timeout_idle: got ready/valid=%b want 10", {o_cmd_ready, o_rsp_valid});
        end
        issue(2'b00, 32'h60, 32'h4, 64'h5, 64'h6);
        total++;
        if ({o_se_control, o_se_add, o_se_data_in} !== {64'h0000_0060_0000_0004, 64'h5, 64'h6}) begin
            bad++;
            $display("FAIL timeout_next_bus: got ctl=%h add=%h data=%h want 0000006000000004/5/6",
                     o_se_control, o_se_add, o_se_data_in);
        end
        tick();
        tick();
        total++;
        if ({o_rsp_valid, o_rsp_timeout, o_rsp_data} !== {1'b1, 1'b0, 64'h0}) begin
            bad++;
            $display("FAIL timeout_next_rsp: got valid=%b to=%b data=%h want 1/0/0", o_rsp_valid, o_rsp_timeout, o_rsp_data);
        end
        i_rsp_ready = 1'b1;
        tick();
        i_rsp_ready = 1'b0;
        $display("txn timeout done");
    endtask

    task automatic test_back_to_back();
        i_rsp_ready   = 1'b0;
        i_se_data_out = 64'h0BAD_F00D_1234_5678;
        $display("cmd op=0 module=00000030 ctrl=00000007 add=1 data=2 (followed by held READ)");
        i_cmd_op = 2'b00; i_cmd_module = 32'h30; i_cmd_ctrl = 32'h7; i_cmd_add = 64'h1; i_cmd_data = 64'h2;
        i_cmd_valid = 1'b1;
        tick();
        i_cmd_op = 2'b01; i_cmd_module = 32'h70; i_cmd_ctrl = 32'h3; i_cmd_add = 64'h10; i_cmd_data = 64'h0;
        total++;
        if ({o_se_control, o_cmd_ready} !== {64'h0000_0030_0000_0007, 1'b0}) begin
            bad++;
            $display("FAIL b2b_first_bus: got ctl=%h ready=%b want 0000003000000007/0", o_se_control, o_cmd_ready);
        end
        tick();
        tick();
        for (int k = 3; k <= 7; k++) begin
            total++;
            if ({o_rsp_valid, o_rsp_data, o_cmd_ready, o_se_control} !==
                {1'b1, 64'h0, 1'b0, 64'h0000_0030_0000_0000}) begin
                bad++;
                $display("FAIL b2b_stall_n%0d: got valid=%b data=%h ready=%b ctl=%h want 1/0/0/0000003000000000",
                         k, o_rsp_valid, o_rsp_data, o_cmd_ready, o_se_control);
            end
            if (k == 7) i_rsp_ready = 1'b1;
            tick();
        end
        i_rsp_ready = 1'b0;
        total++;
        if ({o_rsp_valid, o_cmd_ready} !== 2'b01) begin
            bad++;
            $display("FAIL b2b_handshake: got valid/ready=%b want 01", {o_rsp_valid, o_cmd_ready});
        end
        tick();
        i_cmd_valid = 1'b0;
        total++;
        if ({o_se_control, o_se_add, o_cmd_ready} !== {64'h0000_0070_0000_0003, 64'h10, 1'b0}) begin
            bad++;
            $display("FAIL b2b_second_bus: got ctl=%h add=%h ready=%b want 0000007000000003/10/0",
                     o_se_control, o_se_add, o_cmd_ready);
        end
        repeat (4) tick();
        total++;
        if ({o_rsp_valid, o_rsp_data} !== {1'b1, 64'h0BAD_F00D_1234_5678}) begin
            bad++;
            $display("FAIL b2b_second_rsp: got valid=%b data=%h want 1/0badf00d12345678", o_rsp_valid, o_rsp_data);
        end
        i_rsp_ready = 1'b1;
        tick();
        i_rsp_ready = 1'b0;
        $display("txn back_to_back done");
    endtask

    task automatic test_reset_midop();
        i_rsp_ready = 1'b0;
        i_se_end_op = 1'b0;
        issue(2'b10, 32'h40, 32'h1, 64'h0, 64'h0);
        repeat (5) tick();
        #1 i_rst = 1'b1;
        #1;
        total++;
        if ({o_rsp_valid, o_rsp_timeout, o_rsp_data, o_se_data_in, o_se_add, o_se_control} !== '0) begin
            bad++;
            $display("FAIL midop_reset_outputs: got valid=%b data=%h ctl=%h want all 0",
                     o_rsp_valid, o_rsp_data, o_se_control);
        end
        total++;
        if (o_cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL midop_reset_ready: got %b want 1", o_cmd_ready);
        end
        tick();
        i_rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            total++;
            if ({o_rsp_valid, o_cmd_ready} !== 2'b01) begin
                bad++;
                $display("FAIL midop_no_rsp_c%0d: got valid/ready=%b want 01", k, {o_rsp_valid, o_cmd_ready});
            end
            tick();
        end
        issue(2'b11, 32'h20, 32'h55, 64'h7, 64'h8);
        total++;
        if ({o_se_control, o_se_add} !== {64'h0, 64'h7}) begin
            bad++;
            $display("FAIL deselect_bus: got ctl=%h add=%h want 0/7", o_se_control, o_se_add);
        end
        tick();
        tick();
        total++;
        if ({o_rsp_valid, o_rsp_data, o_se_control} !== {1'b1, 64'h0, 64'h0}) begin
            bad++;
            $display("FAIL deselect_rsp: got valid=%b data=%h ctl=%h want 1/0/0", o_rsp_valid, o_rsp_data, o_se_control);
        end
        i_rsp_ready = 1'b1;
        tick();
        i_rsp_ready = 1'b0;
        $display("txn reset_midop done");
    endtask

    initial begin
        i_rst         = 1'b1;
        i_cmd_valid   = 1'b0;
        i_cmd_op      = 2'b00;
        i_cmd_module  = '0;
        i_cmd_ctrl    = '0;
        i_cmd_add     = '0;
        i_cmd_data    = '0;
        i_rsp_ready   = 1'b0;
        i_se_data_out = '0;
        i_se_end_op   = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_exec();
        test_timeout();
        test_back_to_back();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/se_bus_master.md
# se_bus_master

Command sequencer that sits directly upstream of the secure-element top-level and drives its 64-bit data/address/control bus. It accepts host commands over a valid/ready interface and drives them onto the bus with the correct hold time. For long operations it waits for the selected core's end-of-operation flag, with a bounded timeout. It returns one response per command (read data, elapsed cycles, timeout status) over a second valid/ready interface.

## Interface
- DRIVE_CYC, 2: cycles each command's fields are held on the bus (≥1)
- READ_LAT, 2: extra hold cycles before sampling read data (≥1)
- TIMEOUT_W, 24: width of the EXEC cycle counter; timeout at 2^TIMEOUT_W−1
- i_clk  in  1  single clock
- i_rst  in  1  reset, asynchronous, active-high
- i_cmd_valid  in  1  command present
- o_cmd_ready  out  1  sequencer idle, command accepted on valid&ready
- i_cmd_op  in  2  00 WRITE, 01 READ, 10 EXEC, 11 DESELECT
- i_cmd_module  in  32  module address (0x20 SHA2, 0x30 SHA3, 0x40 EdDSA, 0x50 X25519, 0x60 TRNG, 0x70 AES)
- i_cmd_ctrl  in  32  module control word
- i_cmd_add  in  64  word address
- i_cmd_data  in  64  write data
- o_rsp_valid  out  1  response present, held until accepted
- i_rsp_ready  in  1  host accepts response
- o_rsp_data  out  64  READ data / EXEC elapsed cycles / 0
- o_rsp_timeout  out  1  EXEC ended by timeout
- o_se_data_in  out  64  to secure-element data input
- o_se_add  out  64  to secure-element address
- o_se_control  out  64  [63:32] module address, [31:0] control
- i_se_data_out  in  64  from secure-element
- i_se_end_op  in  1  from secure-element

## Operation
- States: IDLE, DRIVE, READ_WAIT, EXEC_WAIT, RESP.
- IDLE: o_cmd_ready=1. On accept, latch fields, go to DRIVE.
- DRIVE: o_se_add, o_se_data_in and o_se_control = {module, ctrl} are held for DRIVE_CYC cycles.
  - WRITE: goes to RESP with data 0.
  - READ: goes to READ_WAIT, fields unchanged.
  - EXEC: goes to EXEC_WAIT.
  - DESELECT: drives module field 0 and ctrl 0, then goes to RESP.
- READ_WAIT: fields are held for READ_LAT more cycles. i_se_data_out is sampled on the last cycle into o_rsp_data, then go to RESP.
- EXEC_WAIT: o_se_control[31:0] returns to 0; the module field is kept.
  - i_se_end_op is ignored for the first 2 cycles (a stale flag from the previous op).
  - After that, the first cycle with end_op=1 → RESP, o_rsp_data = cycles spent in EXEC_WAIT, zero-extended.
  - If the counter reaches 2^TIMEOUT_W−1 first → RESP with o_rsp_timeout=1 and data = counter value.
- RESP: o_rsp_valid=1, outputs stable until i_rsp_ready, then IDLE. The response is always one per command and in order.
- Module-select persistence: after any non-DESELECT command, o_se_control[63:32] keeps the last module address. The downstream per-core reset is gated by the module select, so deselection must only happen via DESELECT.
- After every command, o_se_control[31:0] returns to 0 and o_se_add/o_se_data_in return to 0.

## Timing
- All outputs are registered. Reset value of every output is 0, except o_cmd_ready=1. State is IDLE.
- A command accepted at edge T appears on the bus from T+1.
  - WRITE/DESELECT: rsp_valid at T+1+DRIVE_CYC.
  - READ: data sampled at the end of cycle T+DRIVE_CYC+READ_LAT; rsp_valid at T+1+DRIVE_CYC+READ_LAT.
- EXEC minimum latency is DRIVE_CYC+3 cycles to rsp_valid.
- i_cmd_valid during a busy state is ignored (ready=0). No command is lost, because the host holds valid.
- RESP with i_rsp_ready already high: one-cycle response; ready rises in the next cycle.
- Reset mid-operation: immediate return to reset values. No response is issued for the aborted command.
- Counter saturates and does not wrap.

## Structure
- Package se_bus_pkg:
  - opcode localparams
  - module address constants 0x20–0x70
  - state encoding
  - bus field slice positions
- Sub-module se_op_timer: a loadable counter shared by the DRIVE, READ_WAIT and EXEC_WAIT counts. It provides clear, enable, a terminal-count compare input, and saturation.

## Test plan
- WRITE module 0x50, ctrl 0x1, add 0x3, data 0xDEAD_BEEF → bus shows {0x50,0x1}/0x3/0xDEADBEEF for exactly 2 cycles, then ctrl 0 with module 0x50 kept; rsp data 0, timeout 0.
- READ module 0x20 with core returning 0x0123_4567_89AB_CDEF → rsp_data 0x0123456789ABCDEF, rsp_valid 5 cycles after accept.
- EXEC module 0x40, end_op stuck high from the prior op and falling in wait cycle 1, rising again at wait cycle 10 → rsp_data 10, timeout 0.
- EXEC with TIMEOUT_W=4 and end_op never high → rsp_timeout 1, rsp_data 15, next command accepted normally.
- Back-to-back commands with i_rsp_ready held low 5 cycles → response stable, o_cmd_ready 0 throughout; second command starts only after the handshake.
- Assert i_rst during EXEC_WAIT → all outputs 0, o_cmd_ready 1 on the next cycle, no rsp_valid pulse; DESELECT afterwards drives module field 0.
